// File: rtl/w_rom_ctrl.sv
// rtl/w_rom_ctrl.sv - weight ROM burn-in sequencer and round-robin burst read scheduler (option macro: W_ROM_CTRL_BURN_EN)
module w_rom_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_DEPTH  = 512,
  parameter int ADDR_WIDTH  = $clog2(DATA_DEPTH),
  parameter int LEN_WIDTH   = ADDR_WIDTH,
  parameter int ROM_LATENCY = 1,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  output logic                            rom_r_en,
  output logic                            rom_burn_in_en,
  input  logic                            rom_burned,
  output logic                            rd_valid,
  output logic [ID_WIDTH-1:0]             rd_id,
  output logic                            rd_last,
  output logic                            ready,
  output logic                            busy
);

  typedef enum logic [1:0] {BURN, IDLE, BURST} state_t;

`ifdef W_ROM_CTRL_BURN_EN
  localparam state_t RESET_STATE = BURN;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [NUM_REQ-1:0]    gnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  ren_d;
  logic                  busy_d;
  logic                  ready_d;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   cand_id;
  int                    cand;

  logic [ADDR_WIDTH-1:0] base_arr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];

  logic                  pipe_v  [ROM_LATENCY];
  logic [ID_WIDTH-1:0]   pipe_id [ROM_LATENCY];
  logic                  pipe_l  [ROM_LATENCY];
  logic                  beat_last;
  logic [ID_WIDTH-1:0]   beat_id;

`ifdef W_ROM_CTRL_BURN_EN
  logic                  burn_q, burn_d;
  assign rom_burn_in_en = burn_q;
`else
  logic                  unused_burned;
  assign unused_burned  = rom_burned;
  assign rom_burn_in_en = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign base_arr[g] = req_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
  end

  assign addr_inc = (rom_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : rom_addr + 1'b1;

  // Round-robin pick: scan from the far end so the candidate nearest the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_WIDTH'(cand);
      if (req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    gnt_d   = '0;
    addr_d  = rom_addr;
    ren_d   = 1'b0;
    busy_d  = 1'b0;
    ready_d = ready;
`ifdef W_ROM_CTRL_BURN_EN
    burn_d  = 1'b0;
`endif
    case (state_q)
      BURN: begin
`ifdef W_ROM_CTRL_BURN_EN
        if (rom_burned) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          burn_d = 1'b1;
        end
`else
        state_d = IDLE;
        ready_d = 1'b1;
`endif
      end
      IDLE: begin
        ready_d = 1'b1;
        // Arbitration starts only once ready is visible to the engines.
        if (ready && win_found) begin
          state_d        = BURST;
          gnt_d[win_id]  = 1'b1;
          addr_d         = base_arr[win_id];
          cnt_d          = len_arr[win_id];
          id_d           = win_id;
          ren_d          = 1'b1;
          busy_d         = 1'b1;
          ptr_d          = (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
      end
      BURST: begin
        // The beat on the bus with counter zero is the last one.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_inc;
          cnt_d  = cnt_q - 1'b1;
          ren_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State, pointer, burst counter and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= RESET_STATE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      gnt      <= '0;
      rom_addr <= '0;
      rom_r_en <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
`ifdef W_ROM_CTRL_BURN_EN
      burn_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      gnt      <= gnt_d;
      rom_addr <= addr_d;
      rom_r_en <= ren_d;
      busy     <= busy_d;
      ready    <= ready_d;
`ifdef W_ROM_CTRL_BURN_EN
      burn_q   <= burn_d;
`endif
    end
  end

  assign beat_last = rom_r_en && (cnt_q == '0);
  assign beat_id   = rom_r_en ? id_q : '0;

  // Return sideband delay line, aligned to the ROM read latency.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_id[i] <= '0;
        pipe_l[i]  <= 1'b0;
      end
    end else begin
      pipe_v[0]  <= rom_r_en;
      pipe_id[0] <= beat_id;
      pipe_l[0]  <= beat_last;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
        pipe_l[i]  <= pipe_l[i-1];
      end
    end
  end

  assign rd_valid = pipe_v[ROM_LATENCY-1];
  assign rd_id    = pipe_id[ROM_LATENCY-1];
  assign rd_last  = pipe_l[ROM_LATENCY-1];

endmodule

// File: tb/tb_w_rom_ctrl.sv
// tb/tb_w_rom_ctrl.sv - self-checking bench for w_rom_ctrl with a schedule-level reference model
`timescale 1ns/1ps
module tb_w_rom_ctrl;

  localparam int NR = 4, DEPTH = 512, AW = 9, LW = 9, LAT = 2, IW = 2, MAXC = 2048;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  req_base = '0;
  logic [NR*LW-1:0]  req_len = '0;
  logic              rom_burned = 1'b0;
  logic [NR-1:0]     gnt;
  logic [AW-1:0]     rom_addr;
  logic              rom_r_en, rom_burn_in_en, rd_valid, rd_last, ready, busy;
  logic [IW-1:0]     rd_id;

  w_rom_ctrl #(.NUM_REQ(NR), .DATA_DEPTH(DEPTH), .ROM_LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_base(req_base), .req_len(req_len),
    .gnt(gnt), .rom_addr(rom_addr), .rom_r_en(rom_r_en), .rom_burn_in_en(rom_burn_in_en),
    .rom_burned(rom_burned), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last),
    .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model: expected activity per cycle since the last reset release.
  int          cyc = 0;
  int          done_edge = -1;
  int          next_ok = 0;
  int          ptr = 0;
  int          m_w, m_len, m_base;
  bit [NR-1:0] e_gnt [MAXC];
  bit          e_ren [MAXC];
  int          e_addr[MAXC];
  bit          e_rdv [MAXC];
  int          e_rdid[MAXC];
  bit          e_rdl [MAXC];

  function automatic bit exp_ready(input int c);
`ifdef W_ROM_CTRL_BURN_EN
    return (done_edge >= 0) && (c >= done_edge);
`else
    return c >= 1;
`endif
  endfunction

  function automatic bit exp_burn(input int c);
`ifdef W_ROM_CTRL_BURN_EN
    return (c >= 1) && ((done_edge < 0) || (c < done_edge));
`else
    return (c < 0);
`endif
  endfunction

  // Each edge: decide whether a grant happens and lay out the whole burst in the schedule.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cyc = 0; done_edge = -1; next_ok = 0; ptr = 0;
      for (int i = 0; i < MAXC; i++) begin
        e_gnt[i] = '0; e_ren[i] = 0; e_addr[i] = 0; e_rdv[i] = 0; e_rdid[i] = 0; e_rdl[i] = 0;
      end
    end else begin
      cyc++;
      if (done_edge < 0 && rom_burned) done_edge = cyc;
      if (exp_ready(cyc - 1) && cyc >= next_ok && req != '0) begin
        m_w = -1;
        for (int k = 0; k < NR; k++)
          if (m_w < 0 && req[(ptr + k) % NR]) m_w = (ptr + k) % NR;
        m_len  = int'(req_len[m_w*LW +: LW]);
        m_base = int'(req_base[m_w*AW +: AW]);
        if (cyc < MAXC) e_gnt[cyc] = NR'(1 << m_w);
        for (int b = 0; b <= m_len; b++) begin
          if (cyc + b + LAT < MAXC) begin
            e_ren[cyc+b]      = 1;
            e_addr[cyc+b]     = (m_base + b) % DEPTH;
            e_rdv[cyc+b+LAT]  = 1;
            e_rdid[cyc+b+LAT] = m_w;
            e_rdl[cyc+b+LAT]  = (b == m_len);
          end
        end
        next_ok = cyc + m_len + 2;
        ptr     = (m_w + 1) % NR;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      chk("reset_outputs", {gnt, rom_addr, rom_r_en, rom_burn_in_en, rd_valid, rd_id, rd_last, ready, busy}, 0);
    end else if (cyc < MAXC) begin
      chk("gnt", gnt, e_gnt[cyc]);
      chk("rom_r_en", rom_r_en, e_ren[cyc]);
      if (e_ren[cyc]) chk("rom_addr", rom_addr, e_addr[cyc]);
      chk("busy", busy, e_ren[cyc]);
      chk("rd_valid", rd_valid, e_rdv[cyc]);
      chk("rd_id", rd_id, e_rdid[cyc]);
      chk("rd_last", rd_last, e_rdl[cyc]);
      chk("ready", ready, exp_ready(cyc));
      chk("rom_burn_in_en", rom_burn_in_en, exp_burn(cyc));
    end
  end

  int q_addr[$];
  int q_rdid[$];
  int q_rdl[$];
  int got_gnt;

  task automatic do_burst(input int id, input int base, input int len, input int ncyc);
    q_addr.delete(); q_rdid.delete(); q_rdl.delete(); got_gnt = 0;
    @(negedge clk);
    req_base[id*AW +: AW] = AW'(base);
    req_len[id*LW +: LW]  = LW'(len);
    req[id] = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (gnt[id]) begin req[id] = 1'b0; got_gnt++; end
      if (rom_r_en) q_addr.push_back(int'(rom_addr));
      if (rd_valid) begin q_rdid.push_back(int'(rd_id)); q_rdl.push_back(int'(rd_last)); end
    end
    req[id] = 1'b0;
    chk("burst_gnt_once", got_gnt, 1);
  endtask

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  int ea_single[4] = '{10, 11, 12, 13};
  int ea_wrap[4]   = '{510, 511, 0, 1};
  int el_single[4] = '{0, 0, 0, 1};
  int exp_rr[6]    = '{0, 1, 2, 3, 0, 1};
  int rr_id[6];
  int rr_cyc[6];
  int rr_n, first_cyc, burn_cnt, rdv_cnt, last_cnt, got;
  logic [NR-1:0] first_g;

  initial begin
    // Power-up: requester 2 waits through reset (and burn-in when present).
    repeat (3) @(negedge clk);
    req_base[2*AW +: AW] = 9'd7;
    req_len[2*LW +: LW]  = '0;
    req[2] = 1'b1;
    #2 rst_b = 1'b1;
    first_cyc = -1; burn_cnt = 0; first_g = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rom_burn_in_en) burn_cnt++;
      if (gnt != '0 && first_cyc < 0) begin first_cyc = i; first_g = gnt; end
      if (gnt[2]) req[2] = 1'b0;
      rom_burned = (i == 10);
    end
`ifdef W_ROM_CTRL_BURN_EN
    chk("burn_cycles", burn_cnt, 10);
    chk("first_gnt_cycle", first_cyc, 12);
`else
    chk("burn_cycles", burn_cnt, 0);
    chk("first_gnt_cycle", first_cyc, 2);
`endif
    chk("first_gnt_id", first_g, 4'b0100);

    // Single 4-beat burst from requester 1.
    do_burst(1, 10, 3, 12);
    chk("single_beats", q_addr.size(), 4);
    chk("single_rd_beats", q_rdid.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("single_addr", q_addr[i], ea_single[i]);
    for (int i = 0; i < 4 && i < q_rdid.size(); i++) begin
      chk("single_rd_id", q_rdid[i], 1);
      chk("single_rd_last", q_rdl[i], el_single[i]);
    end

    // Address wrap at the top of the ROM.
    do_burst(3, 510, 3, 12);
    chk("wrap_beats", q_addr.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("wrap_addr", q_addr[i], ea_wrap[i]);

    // Round-robin with all requesters asking for single beats.
    for (int r = 0; r < NR; r++) begin
      req_base[r*AW +: AW] = AW'(r * 50);
      req_len[r*LW +: LW]  = '0;
    end
    @(negedge clk);
    req = '1; rr_n = 0;
    for (int i = 0; i < 30 && rr_n < 6; i++) begin
      @(negedge clk);
      if (gnt != '0) begin rr_id[rr_n] = oh_idx(gnt); rr_cyc[rr_n] = cyc; rr_n++; end
    end
    req = '0;
    chk("rr_count", rr_n, 6);
    for (int i = 0; i < rr_n; i++) begin
      chk("rr_order", rr_id[i], exp_rr[i]);
      if (i > 0) chk("rr_gap", rr_cyc[i] - rr_cyc[i-1], 2);
    end
    repeat (4) @(negedge clk);

    // Maximum length: 512 beats covering the whole ROM once.
    do_burst(0, 5, 511, 520);
    chk("max_beats", q_addr.size(), 512);
    if (q_addr.size() == 512) begin
      chk("max_addr_first", q_addr[0], 5);
      chk("max_addr_top", q_addr[506], 511);
      chk("max_addr_wrap", q_addr[507], 0);
      chk("max_addr_end", q_addr[511], 4);
    end
    last_cnt = 0;
    foreach (q_rdl[i]) last_cnt += q_rdl[i];
    chk("max_rd_beats", q_rdl.size(), 512);
    chk("max_last_count", last_cnt, 1);

    // Reset during the second beat of a 5-beat burst from requester 2.
    req_base[2*AW +: AW] = 9'd100;
    req_len[2*LW +: LW]  = 9'd4;
    @(negedge clk);
    req[2] = 1'b1; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (gnt[2]) got = 1;
    end
    req[2] = 1'b0;
    chk("mid_gnt_seen", got, 1);
    @(negedge clk);
    chk("mid_second_beat", {rom_r_en, rom_addr}, {1'b1, 9'd101});
    #2 rst_b = 1'b0;
    #1 chk("mid_reset_outputs", {gnt, rom_addr, rom_r_en, rom_burn_in_en, rd_valid, rd_id, rd_last, ready, busy}, 0);
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b1;
    first_g = '0; rdv_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_base[0*AW +: AW] = 9'd20;
        req_base[3*AW +: AW] = 9'd30;
        req_len[0*LW +: LW]  = '0;
        req_len[3*LW +: LW]  = '0;
        req[0] = 1'b1; req[3] = 1'b1;
`ifdef W_ROM_CTRL_BURN_EN
        chk("burn_again", rom_burn_in_en, 1);
`else
        chk("burn_again", rom_burn_in_en, 0);
`endif
      end
      if (i <= 3 && rd_valid) rdv_cnt++;
      if (gnt != '0 && first_g == '0) begin first_g = gnt; req = '0; end
      rom_burned = (i == 3);
    end
    req = '0;
    chk("post_reset_no_rd_valid", rdv_cnt, 0);
    chk("post_reset_first_gnt", first_g, 4'b0001);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
